// File: rtl/alu_issue_scheduler.sv
// Round-robin issue of NumReq requesters onto one shared 1-cycle ALU, with a 2-entry result FIFO toward the CDB.
// Define ALU_SCHED_STATS_EN to add the stat_issued_o / stat_stall_o counters.
module alu_issue_scheduler #(
  parameter int NumReq            = 4,
  parameter int DatapathWidth     = 32,
  parameter int AluOperationWidth = 5,
  parameter int TagWidth          = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq*AluOperationWidth-1:0]   req_op_i,
  input  logic [NumReq*DatapathWidth-1:0]       req_operand1_i,
  input  logic [NumReq*DatapathWidth-1:0]       req_operand2_i,
  input  logic [NumReq*DatapathWidth-1:0]       req_immediate_i,
  input  logic [NumReq*DatapathWidth-1:0]       req_pc_i,
  input  logic [NumReq*TagWidth-1:0]            req_tag_i,
  output logic [AluOperationWidth-1:0]          alu_operation_o,
  output logic [DatapathWidth-1:0]              alu_operand1_o,
  output logic [DatapathWidth-1:0]              alu_operand2_o,
  output logic [DatapathWidth-1:0]              alu_immediate_o,
  output logic [DatapathWidth-1:0]              alu_pc_o,
  input  logic [DatapathWidth-1:0]              alu_result_i,
  input  logic                                  alu_branch_taken_i,
  output logic                                  cdb_valid_o,
  input  logic                                  cdb_ready_i,
  output logic [TagWidth-1:0]                   cdb_tag_o,
  output logic [DatapathWidth-1:0]              cdb_result_o,
  output logic                                  cdb_branch_taken_o
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [31:0]                           stat_issued_o,
  output logic [31:0]                           stat_stall_o
`endif
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0]          rr_q;
  logic                     inflight_q;
  logic [TagWidth-1:0]      tag_q;
  logic [1:0]               fifo_cnt_q;
  logic                     wr_ptr_q;
  logic                     rd_ptr_q;
  logic [TagWidth-1:0]      fifo_tag_q    [2];
  logic [DatapathWidth-1:0] fifo_result_q [2];
  logic                     fifo_branch_q [2];

  logic                     grant_any;
  logic [PtrW-1:0]          grant_idx;
  logic [2:0]               occupancy;
  logic                     issue_ok;
  logic                     issue;
  logic                     push;
  logic                     pop;

  // Search forward from the rr pointer, wrapping modulo NumReq.
  always_comb begin
    logic [PtrW:0]   sum;
    logic [PtrW-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      sum = {1'b0, rr_q} + (PtrW+1)'(k);
      if (sum >= (PtrW+1)'(NumReq)) sum = sum - (PtrW+1)'(NumReq);
      cand = sum[PtrW-1:0];
      if (!grant_any && req_valid_i[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Credits: FIFO entries plus the op in the ALU must leave room for one more result.
  assign pop       = cdb_valid_o & cdb_ready_i;
  assign push      = inflight_q;
  assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_ok  = rst_ni && (occupancy < 3'd2);
  assign issue     = issue_ok & grant_any;

  always_comb begin
    req_ready_o = '0;
    if (issue) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    alu_operation_o = '0;
    alu_operand1_o  = '0;
    alu_operand2_o  = '0;
    alu_immediate_o = '0;
    alu_pc_o        = '0;
    if (issue) begin
      alu_operation_o = req_op_i[grant_idx*AluOperationWidth +: AluOperationWidth];
      alu_operand1_o  = req_operand1_i[grant_idx*DatapathWidth +: DatapathWidth];
      alu_operand2_o  = req_operand2_i[grant_idx*DatapathWidth +: DatapathWidth];
      alu_immediate_o = req_immediate_i[grant_idx*DatapathWidth +: DatapathWidth];
      alu_pc_o        = req_pc_i[grant_idx*DatapathWidth +: DatapathWidth];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_q <= req_tag_i[grant_idx*TagWidth +: TagWidth];
        rr_q  <= (grant_idx == PtrW'(NumReq-1)) ? '0 : grant_idx + PtrW'(1);
      end
    end
  end

  // With two entries full a push never coincides with a needed slot, so write-then-read order is safe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        fifo_tag_q[e]    <= '0;
        fifo_result_q[e] <= '0;
        fifo_branch_q[e] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_tag_q[wr_ptr_q]    <= tag_q;
        fifo_result_q[wr_ptr_q] <= alu_result_i;
        fifo_branch_q[wr_ptr_q] <= alu_branch_taken_i;
        wr_ptr_q                <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign cdb_valid_o        = (fifo_cnt_q != 2'd0);
  assign cdb_tag_o          = fifo_tag_q[rd_ptr_q];
  assign cdb_result_o       = fifo_result_q[rd_ptr_q];
  assign cdb_branch_taken_o = fifo_branch_q[rd_ptr_q];

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && fifo_cnt_q == 2'd2));

`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_issued_o <= '0;
      stat_stall_o  <= '0;
    end else begin
      if (issue) stat_issued_o <= stat_issued_o + 32'd1;
      if (|req_valid_i && !issue) stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

endmodule
